// File: rtl/regs_pkg.sv
// regs_pkg: shared constants for the 8-entry, 8-bit register file and its
// write-port arbiter.
//   REG_AW / REG_DW : register address / data widths
//   REG_N           : number of registers
//   REG_WPORTS      : register-file write ports driven by the arbiter
//   REG_WREQS       : number of datapath write requesters
//   B..A            : register indices as used by the datapath
package regs_pkg;

  localparam int REG_AW     = 3;
  localparam int REG_DW     = 8;
  localparam int REG_N      = 8;
  localparam int REG_WPORTS = 4;
  localparam int REG_WREQS  = 6;

  localparam logic [REG_AW-1:0] B = 3'd0;
  localparam logic [REG_AW-1:0] C = 3'd1;
  localparam logic [REG_AW-1:0] D = 3'd2;
  localparam logic [REG_AW-1:0] E = 3'd3;
  localparam logic [REG_AW-1:0] H = 3'd4;
  localparam logic [REG_AW-1:0] L = 3'd5;
  localparam logic [REG_AW-1:0] M = 3'd6;
  localparam logic [REG_AW-1:0] A = 3'd7;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

endpackage

// File: rtl/regs_write_sel.sv
// regs_write_sel: combinational scan/grant/port-assignment for the register
// write arbiter. Requesters are visited from 'start', wrapping modulo NREQ;
// a valid requester is granted while fewer than NPORT grants exist and its
// address is not already granted. The k-th grant lands on port k.
// Ports:
//   start      : first requester index of the scan
//   req_valid  : per-requester write offer
//   req_addr   : requester i address at [i*AW +: AW]
//   req_data   : requester i data at [i*DW +: DW]
//   grant      : per-requester grant
//   port_en    : port k carries a grant
//   port_addr  : port k address at [k*AW +: AW] (zero when unused)
//   port_data  : port k data at [k*DW +: DW] (zero when unused)
//   any_grant  : at least one grant this cycle
//   last_idx   : index of the last requester granted in scan order
module regs_write_sel
  import regs_pkg::*;
#(
  parameter int NREQ  = REG_WREQS,
  parameter int NPORT = REG_WPORTS,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [PW-1:0]       start,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     grant,
  output logic [NPORT-1:0]    port_en,
  output logic [NPORT*AW-1:0] port_addr,
  output logic [NPORT*DW-1:0] port_data,
  output logic                any_grant,
  output logic [PW-1:0]       last_idx
);

  localparam int CW = $clog2(NPORT + 1);
  // One extra bit so start + j cannot overflow before the modulo fold.
  localparam int IW = PW + 1;

  logic [IW-1:0]     pos;
  logic [PW-1:0]     idx;
  logic [AW-1:0]     addr;
  logic [CW-1:0]     count;
  logic [2**AW-1:0]  taken;

  // Single pass over requesters in rotated order; 'taken' tracks addresses
  // already granted this cycle so the same register is never written twice.
  always_comb begin
    grant     = '0;
    port_en   = '0;
    port_addr = '0;
    port_data = '0;
    any_grant = 1'b0;
    last_idx  = '0;
    count     = '0;
    taken     = '0;
    pos       = '0;
    idx       = '0;
    addr      = '0;
    for (int j = 0; j < NREQ; j++) begin
      pos = {1'b0, start} + IW'(j);
      if (pos >= IW'(NREQ)) begin
        pos = pos - IW'(NREQ);
      end
      idx  = pos[PW-1:0];
      addr = req_addr[idx*AW +: AW];
      if (req_valid[idx] && (count < CW'(NPORT)) && !taken[addr]) begin
        grant[idx]  = 1'b1;
        taken[addr] = 1'b1;
        for (int k = 0; k < NPORT; k++) begin
          if (count == CW'(k)) begin
            port_en[k]              = 1'b1;
            port_addr[k*AW +: AW]   = addr;
            port_data[k*DW +: DW]   = req_data[idx*DW +: DW];
          end
        end
        count     = count + CW'(1);
        any_grant = 1'b1;
        last_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/regs_write_arb.sv
// regs_write_arb: write-port arbiter for the 8-entry register file.
// Grants up to NPORT writes per cycle (never two to one address) and
// registers them onto the register file's wen/waddr/wdata ports.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   req_valid  : requester i offers a write
//   req_addr   : requester i address at [i*AW +: AW]
//   req_data   : requester i data at [i*DW +: DW]
//   req_ready  : requester i granted this cycle (combinational)
//   wen        : registered per-port write enables
//   waddr      : registered port addresses, port k at [k*AW +: AW]
//   wdata      : registered port data, port k at [k*DW +: DW]
//   pend_mask  : register r has a write in flight on some port
//   stall      : some valid requester was not granted (combinational)
// Configuration macro: REGS_WRITE_ARB_RR_EN
//   defined   -> rotating rr_ptr, round-robin fairness
//   undefined -> scan always starts at requester 0 (fixed priority)
module regs_write_arb
  import regs_pkg::*;
#(
  parameter int NREQ  = REG_WREQS,
  parameter int NPORT = REG_WPORTS,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [NPORT-1:0]    wen,
  output logic [NPORT*AW-1:0] waddr,
  output logic [NPORT*DW-1:0] wdata,
  output logic [2**AW-1:0]    pend_mask,
  output logic                stall
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]       start;
  logic [PW-1:0]       last_idx;
  logic                any_grant;
  logic [NREQ-1:0]     sel_grant;
  logic [NPORT-1:0]    port_en;
  logic [NPORT*AW-1:0] port_addr;
  logic [NPORT*DW-1:0] port_data;

  regs_write_sel #(
    .NREQ  (NREQ),
    .NPORT (NPORT),
    .AW    (AW),
    .DW    (DW)
  ) u_sel (
    .start     (start),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .grant     (sel_grant),
    .port_en   (port_en),
    .port_addr (port_addr),
    .port_data (port_data),
    .any_grant (any_grant),
    .last_idx  (last_idx)
  );

`ifdef REGS_WRITE_ARB_RR_EN
  logic [PW-1:0] rr_ptr;

  // Next scan starts just after the last requester served; holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (last_idx == PW'(NREQ - 1)) ? '0 : last_idx + PW'(1);
    end
  end

  assign start = rr_ptr;
`else
  logic unused_sel;

  assign start      = '0;
  assign unused_sel = ^{any_grant, last_idx};
`endif

  // Grants are suppressed while reset is held so no requester sees a
  // transfer that the output stage would drop.
  assign req_ready = rst ? '0 : sel_grant;
  assign stall     = !rst && (|(req_valid & ~sel_grant));

  // Unused ports keep their last address/data; only wen says what is live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen   <= '0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      wen <= port_en;
      for (int k = 0; k < NPORT; k++) begin
        if (port_en[k]) begin
          waddr[k*AW +: AW] <= port_addr[k*AW +: AW];
          wdata[k*DW +: DW] <= port_data[k*DW +: DW];
        end
      end
    end
  end

  // Decoded purely from the output flops, so it clears with reset.
  always_comb begin
    pend_mask = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (wen[k]) begin
        pend_mask[waddr[k*AW +: AW]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regs_write_arb.sv
// tb_regs_write_arb: self-checking bench for regs_write_arb.
// Directed vectors drive the requesters; each vector carries its
// hand-computed combinational response (req_ready/stall) and the registered
// write set expected one cycle later, which is pushed into a scoreboard
// queue. A monitor pops and compares whenever the DUT raises any wen bit.
// Expectations follow REGS_WRITE_ARB_RR_EN where the two builds differ.
module tb_regs_write_arb;

  localparam int NREQ  = 6;
  localparam int NPORT = 4;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic [NPORT-1:0]    wen;
  logic [NPORT*AW-1:0] waddr;
  logic [NPORT*DW-1:0] wdata;
  logic [7:0]          pend_mask;
  logic                stall;

  typedef struct packed {
    logic [3:0]  wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [7:0]  pend;
  } exp_t;

  exp_t       sb_q[$];
  int         tests = 0;
  int         failures = 0;
  logic [7:0] rf [8];

  regs_write_arb #(
    .NREQ  (NREQ),
    .NPORT (NPORT),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .pend_mask (pend_mask),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file fed by the DUT write ports.
  always @(posedge clk) begin
    for (int k = 0; k < NPORT; k++) begin
      if (wen[k]) rf[waddr[k*AW +: AW]] <= wdata[k*DW +: DW];
    end
  end

  function automatic exp_t mkExp(input logic [3:0] w, input logic [11:0] a,
                                 input logic [31:0] d, input logic [7:0] p);
    exp_t e;
    e.wen   = w;
    e.waddr = a;
    e.wdata = d;
    e.pend  = p;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] actual,
                             input logic [47:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One cycle of stimulus: drive after the edge, check the combinational
  // response, and queue the write set due on the ports next cycle.
  task automatic applyStimulus(input logic [5:0] v, input logic [17:0] a,
                               input logic [47:0] d, input logic [5:0] exp_ready,
                               input logic exp_stall, input exp_t exp_out);
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    if (exp_out.wen != 4'b0) sb_q.push_back(exp_out);
    #1;
    checkOutput("req_ready", 48'(req_ready), 48'(exp_ready));
    checkOutput("stall", 48'(stall), 48'(exp_stall));
  endtask

  // Monitor: every cycle the DUT presents writes, match them to the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && wen != 4'b0) begin
      if (sb_q.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected_write: got wen 0x%0h, expected no write", wen);
      end else begin
        e = sb_q.pop_front();
        checkOutput("wen", 48'(wen), 48'(e.wen));
        for (int k = 0; k < NPORT; k++) begin
          if (e.wen[k]) begin
            checkOutput($sformatf("waddr%0d", k), 48'(waddr[k*AW +: AW]), 48'(e.waddr[k*3 +: 3]));
            checkOutput($sformatf("wdata%0d", k), 48'(wdata[k*DW +: DW]), 48'(e.wdata[k*8 +: 8]));
          end
        end
        checkOutput("pend_mask", 48'(pend_mask), 48'(e.pend));
      end
    end
  end

  initial begin
    exp_t none;
    none = mkExp(4'b0, 12'h0, 32'h0, 8'h0);

    // Reset state with every requester asking.
    rst       = 1'b0;
    req_valid = 6'h3F;
    req_addr  = '0;
    req_data  = '0;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_wen", 48'(wen), 48'h0);
    checkOutput("reset_pend", 48'(pend_mask), 48'h0);
    checkOutput("reset_ready", 48'(req_ready), 48'h0);
    checkOutput("reset_stall", 48'(stall), 48'h0);
    @(negedge clk);
    req_valid = 6'h0;
    @(negedge clk);
    rst = 1'b0;

    // Six requesters, distinct addresses: four now, two next cycle.
    applyStimulus(6'h3F, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 48'h151413121110,
                  6'b001111, 1'b1,
                  mkExp(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 32'h13121110, 8'h0F));
    applyStimulus(6'b110000, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 48'h151413121110,
                  6'b110000, 1'b0,
                  mkExp(4'b0011, {3'd0, 3'd0, 3'd5, 3'd4}, 32'h00001514, 8'h30));

    // Address conflict on register 7: requester 0 first, 1 the cycle after.
    applyStimulus(6'b000011, {12'd0, 3'd7, 3'd7}, {32'h0, 8'h22, 8'h11},
                  6'b000001, 1'b1, mkExp(4'b0001, {9'd0, 3'd7}, {24'd0, 8'h11}, 8'h80));
    applyStimulus(6'b000010, {12'd0, 3'd7, 3'd7}, {32'h0, 8'h22, 8'h11},
                  6'b000010, 1'b0, mkExp(4'b0001, {9'd0, 3'd7}, {24'd0, 8'h22}, 8'h80));

    // Idle: no writes, nothing pending.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'b0, 18'd0, 48'd0, 6'b0, 1'b0, none);
      if (i > 0) begin
        checkOutput("idle_wen", 48'(wen), 48'h0);
        checkOutput("idle_pend", 48'(pend_mask), 48'h0);
      end
    end

    // Requesters 0..4 always valid.
`ifdef REGS_WRITE_ARB_RR_EN
    applyStimulus(6'b011111, {3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 48'h002423222120,
                  6'b011101, 1'b1,
                  mkExp(4'b1111, {3'd0, 3'd4, 3'd3, 3'd2}, 32'h20242322, 8'h1D));
    applyStimulus(6'b011111, {3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 48'h002423222120,
                  6'b011110, 1'b1,
                  mkExp(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 32'h24232221, 8'h1E));
    applyStimulus(6'b011111, {3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 48'h002423222120,
                  6'b001111, 1'b1,
                  mkExp(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 32'h23222120, 8'h0F));
`else
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'b011111, {3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 48'h002423222120,
                    6'b001111, 1'b1,
                    mkExp(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 32'h23222120, 8'h0F));
    end
`endif

    // Two writes registered, then reset drops them immediately.
    applyStimulus(6'b000011, {12'd0, 3'd6, 3'd5}, {32'h0, 8'h66, 8'h55},
                  6'b000011, 1'b0, none);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_wen", 48'(wen), 48'h3);
    checkOutput("pre_reset_pend", 48'(pend_mask), 48'h60);
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_wen", 48'(wen), 48'h0);
    checkOutput("mid_reset_pend", 48'(pend_mask), 48'h0);
    checkOutput("mid_reset_ready", 48'(req_ready), 48'h0);
    checkOutput("mid_reset_stall", 48'(stall), 48'h0);
    @(negedge clk);
    req_valid = 6'h0;
    @(negedge clk);
    rst = 1'b0;

    // After reset the scan starts from requester 0 again.
    applyStimulus(6'h3F, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 48'h353433323130,
                  6'b001111, 1'b1,
                  mkExp(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 32'h33323130, 8'h0F));
    applyStimulus(6'b110000, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 48'h353433323130,
                  6'b110000, 1'b0,
                  mkExp(4'b0011, {3'd0, 3'd0, 3'd5, 3'd4}, 32'h00003534, 8'h30));

    // Single requester 2 writing 0xA5 to register 4.
    applyStimulus(6'b000100, {9'd0, 3'd4, 6'd0}, {24'd0, 8'hA5, 16'd0},
                  6'b000100, 1'b0, mkExp(4'b0001, {9'd0, 3'd4}, {24'd0, 8'hA5}, 8'h10));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'b0, 18'd0, 48'd0, 6'b0, 1'b0, none);
    end

    checkOutput("rf_reg4", 48'(rf[4]), 48'hA5);
    checkOutput("rf_reg7", 48'(rf[7]), 48'h22);
    checkOutput("sb_drained", 48'(sb_q.size()), 48'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
